// File: rtl/decode_exec_latch.sv
// Decode/execute pipeline latch: captures decode outputs, inserts bubbles on flush or
// load-use hazard, and resolves MEM/WB forwarding onto the latched operands.
module decode_exec_latch #(
   parameter int WORD_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              en,
   input  logic              flush,
   input  logic [WORD_W-1:0] d_alu_in1,
   input  logic [WORD_W-1:0] d_alu_in2,
   input  logic [WORD_W-1:0] d_dmemstore,
   input  logic              d_in2_is_reg,
   input  logic [REG_W-1:0]  d_rs,
   input  logic [REG_W-1:0]  d_rt,
   input  logic [REG_W-1:0]  d_wsel,
   input  logic [3:0]        d_aluop,
   input  logic [1:0]        d_wdat_source,
   input  logic              d_branch_instr,
   input  logic              d_branch_if_zero,
   input  logic              d_halt,
   input  logic              d_dmemREN,
   input  logic              d_dmemWEN,
   input  logic [WORD_W-1:0] d_branch_target,
   input  logic [WORD_W-1:0] d_npc,
   input  logic              m_wen,
   input  logic [REG_W-1:0]  m_wsel,
   input  logic [WORD_W-1:0] m_wdat,
   input  logic              w_wen,
   input  logic [REG_W-1:0]  w_wsel,
   input  logic [WORD_W-1:0] w_wdat,
   output logic [WORD_W-1:0] safe_alu_in1,
   output logic [WORD_W-1:0] safe_alu_in2,
   output logic [WORD_W-1:0] safe_dmemstore,
   output logic              e_in2_is_reg,
   output logic [REG_W-1:0]  e_rs,
   output logic [REG_W-1:0]  e_rt,
   output logic [REG_W-1:0]  e_wsel,
   output logic [3:0]        e_aluop,
   output logic [1:0]        e_wdat_source,
   output logic              e_branch_instr,
   output logic              e_branch_if_zero,
   output logic              e_halt,
   output logic              e_dmemREN,
   output logic              e_dmemWEN,
   output logic [WORD_W-1:0] e_branch_target,
   output logic [WORD_W-1:0] e_npc,
   output logic              e_valid,
   output logic              hazard_stall
);

   logic              valid_q, valid_d;
   logic [WORD_W-1:0] in1_q, in1_d, in2_q, in2_d, st_q, st_d;
   logic              in2r_q, in2r_d;
   logic [REG_W-1:0]  rs_q, rs_d, rt_q, rt_d, wsel_q, wsel_d;
   logic [3:0]        aluop_q, aluop_d;
   logic [1:0]        wds_q, wds_d;
   logic              bi_q, bi_d, biz_q, biz_d, halt_q, halt_d;
   logic              ren_q, ren_d, wen_q, wen_d;
   logic [WORD_W-1:0] bt_q, bt_d, npc_q, npc_d;
   logic              halt_seen_q, halt_seen_d;
   logic              bubble;

   // MEM result is younger than WB, so it wins; $0 is never forwarded.
   function automatic logic [WORD_W-1:0] fwd(
      input logic [REG_W-1:0]  r,
      input logic [WORD_W-1:0] latched,
      input logic              mw,
      input logic [REG_W-1:0]  ms,
      input logic [WORD_W-1:0] md,
      input logic              ww,
      input logic [REG_W-1:0]  ws,
      input logic [WORD_W-1:0] wd
   );
      if (r == '0)             return latched;
      else if (mw && ms == r)  return md;
      else if (ww && ws == r)  return wd;
      else                     return latched;
   endfunction

   always_comb begin
      safe_alu_in1   = fwd(rs_q, in1_q, m_wen, m_wsel, m_wdat, w_wen, w_wsel, w_wdat);
      safe_alu_in2   = in2r_q ? fwd(rt_q, in2_q, m_wen, m_wsel, m_wdat, w_wen, w_wsel, w_wdat)
                              : in2_q;
      safe_dmemstore = fwd(rt_q, st_q, m_wen, m_wsel, m_wdat, w_wen, w_wsel, w_wdat);
   end

   assign hazard_stall = valid_q & ren_q & (wsel_q != '0) &
                         ((d_rs == wsel_q) | ((d_in2_is_reg | d_dmemWEN) & (d_rt == wsel_q)));

   assign bubble = flush | (en & (hazard_stall | halt_seen_q));

   always_comb begin
      valid_d = valid_q;  in1_d = in1_q;    in2_d = in2_q;   st_d = st_q;
      in2r_d  = in2r_q;   rs_d = rs_q;      rt_d = rt_q;     wsel_d = wsel_q;
      aluop_d = aluop_q;  wds_d = wds_q;    bi_d = bi_q;     biz_d = biz_q;
      halt_d  = halt_q;   ren_d = ren_q;    wen_d = wen_q;   bt_d = bt_q;
      npc_d   = npc_q;    halt_seen_d = halt_seen_q;
      if (bubble) begin
         valid_d = 1'b0;  in1_d = '0;   in2_d = '0;   st_d = '0;
         in2r_d  = 1'b0;  rs_d = '0;    rt_d = '0;    wsel_d = '0;
         aluop_d = '0;    wds_d = '0;   bi_d = 1'b0;  biz_d = 1'b0;
         halt_d  = 1'b0;  ren_d = 1'b0; wen_d = 1'b0; bt_d = '0;
         npc_d   = '0;
      end else if (en) begin
         valid_d = 1'b1;          in1_d = d_alu_in1;        in2_d = d_alu_in2;
         st_d    = d_dmemstore;   in2r_d = d_in2_is_reg;    rs_d = d_rs;
         rt_d    = d_rt;          wsel_d = d_wsel;          aluop_d = d_aluop;
         wds_d   = d_wdat_source; bi_d = d_branch_instr;    biz_d = d_branch_if_zero;
         halt_d  = d_halt;        ren_d = d_dmemREN;        wen_d = d_dmemWEN;
         bt_d    = d_branch_target;
         npc_d   = d_npc;
         halt_seen_d = halt_seen_q | d_halt;
      end else begin
         // Hold: fold in results retiring during the stall so they are not lost.
         in1_d = safe_alu_in1;
         in2_d = safe_alu_in2;
         st_d  = safe_dmemstore;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         valid_q <= 1'b0;  in1_q <= '0;   in2_q <= '0;   st_q <= '0;
         in2r_q  <= 1'b0;  rs_q <= '0;    rt_q <= '0;    wsel_q <= '0;
         aluop_q <= '0;    wds_q <= '0;   bi_q <= 1'b0;  biz_q <= 1'b0;
         halt_q  <= 1'b0;  ren_q <= 1'b0; wen_q <= 1'b0; bt_q <= '0;
         npc_q   <= '0;    halt_seen_q <= 1'b0;
      end else begin
         valid_q <= valid_d;  in1_q <= in1_d;  in2_q <= in2_d;  st_q <= st_d;
         in2r_q  <= in2r_d;   rs_q <= rs_d;    rt_q <= rt_d;    wsel_q <= wsel_d;
         aluop_q <= aluop_d;  wds_q <= wds_d;  bi_q <= bi_d;    biz_q <= biz_d;
         halt_q  <= halt_d;   ren_q <= ren_d;  wen_q <= wen_d;  bt_q <= bt_d;
         npc_q   <= npc_d;    halt_seen_q <= halt_seen_d;
      end
   end

   assign e_valid          = valid_q;
   assign e_in2_is_reg     = in2r_q;
   assign e_rs             = rs_q;
   assign e_rt             = rt_q;
   assign e_wsel           = wsel_q;
   assign e_aluop          = aluop_q;
   assign e_wdat_source    = wds_q;
   assign e_branch_instr   = bi_q;
   assign e_branch_if_zero = biz_q;
   assign e_halt           = halt_q;
   assign e_dmemREN        = ren_q;
   assign e_dmemWEN        = wen_q;
   assign e_branch_target  = bt_q;
   assign e_npc            = npc_q;

endmodule

// File: doc/decode_exec_latch.md
# decode_exec_latch

Pipeline register between the decode and execute stages of the 5-stage MIPS pipeline. Captures decode's outputs on each advancing edge and inserts bubbles on flush or load-use hazard. Resolves MEM/WB forwarding onto the latched operands to drive the execute stage's `safe_alu_in1`, `safe_alu_in2` and `safe_dmemstore`. While the pipe is held, it keeps the forwarded operand values alive.

## Interface
- `WORD_W`, default 32: data/address width.
- `REG_W`, default 5: register-select width.
- `CLK` in 1: clock; all state updates on its rising edge.
- `RST` in 1: synchronous, active-high reset.
- `en` in 1: pipeline advance; 0 holds the latch.
- `flush` in 1: replace the next latched entry with a bubble (branch mispredict).
- `d_alu_in1`, `d_alu_in2`, `d_dmemstore` in WORD_W: decode operand values.
- `d_in2_is_reg` in 1: `d_alu_in2` comes from rt (0 means immediate).
- `d_rs`, `d_rt`, `d_wsel` in REG_W: source and destination selects.
- `d_aluop` in 4: ALU operation.
- `d_wdat_source` in 2: writeback data source.
- `d_branch_instr`, `d_branch_if_zero`, `d_halt`, `d_dmemREN`, `d_dmemWEN` in 1: decode control bits.
- `d_branch_target`, `d_npc` in WORD_W: branch target and next PC.
- `m_wen` in 1, `m_wsel` in REG_W, `m_wdat` in WORD_W: MEM-stage writeback (forward source 1).
- `w_wen` in 1, `w_wsel` in REG_W, `w_wdat` in WORD_W: WB-stage writeback (forward source 2).
- `safe_alu_in1`, `safe_alu_in2`, `safe_dmemstore` out WORD_W: forwarded operands to execute.
- `e_*` out: registered copies of every `d_*` control and select field (same widths), plus `e_valid` (1).
- `hazard_stall` out 1: combinational load-use stall request to fetch/decode.

## Operation
- State: one entry of all `d_*` fields plus `e_valid`, and a sticky `halt_seen` flag.
- Bubble: `e_valid`=0, `e_wsel`=0, and REN, WEN, branch, halt, aluop and wdat_source all 0. Data fields are don't-care but are driven to 0.
- Load-use detection:
  - `hazard_stall` = `e_valid & e_dmemREN & e_wsel!=0 & (d_rs==e_wsel | (d_in2_is_reg|d_dmemWEN) & d_rt==e_wsel)`.
- Edge update, priority high to low:
  - RST: bubble, and `halt_seen`=0.
  - flush: bubble.
  - `en & hazard_stall`: bubble; decode holds its instruction upstream.
  - `en & halt_seen`: bubble, so no instruction issues after the halt.
  - `en`: load all `d_*` fields, `e_valid`=1, and `halt_seen |= d_halt`.
  - `!en` (hold): controls unchanged. Operand registers reload with the current forwarded values (see below).
- Forwarding for a register r, operating on registered values:
  - If r==0: no forwarding.
  - Else if `m_wen & m_wsel==r`: `m_wdat`.
  - Else if `w_wen & w_wsel==r`: `w_wdat`.
  - Else: the latched value.
  - MEM has priority over WB.
- Operand mapping:
  - `safe_alu_in1` = fwd(`e_rs`, latched in1).
  - `safe_alu_in2` = `e_in2_is_reg` ? fwd(`e_rt`, latched in2) : latched in2.
  - `safe_dmemstore` = fwd(`e_rt`, latched store).
- Hold refresh: on every `!en` edge, latched in1, in2 and store take their safe values. A producer that retires during a multi-cycle dcache stall is not lost.
- Widths: no arithmetic. Select compares are exact REG_W-bit equality.

## Timing
- Latency: `e_*` reflect `d_*` one edge after a cycle with `en`=1.
- `safe_*` are combinational from registers and the same-cycle `m_*`/`w_*` inputs.
- `hazard_stall` is combinational from `d_*` and registers, valid in the same cycle.
- Reset values: all `e_*`=0, `e_valid`=0, all `safe_*`=0, `halt_seen`=0.
- `hazard_stall` is 0 in the cycle after reset.
- Simultaneous events:
  - flush with `hazard_stall`: single bubble.
  - flush with `!en`: flush wins, bubble loads.
  - RST wins over everything.
- Reset asserted mid-stall clears the entry on that edge; no partial state survives.

## Test plan
- Basic advance: `d_alu_in1`=0x11, `d_aluop`=ADD, `d_wsel`=3, `en`=1 → next cycle `e_valid`=1, `safe_alu_in1`=0x11, `e_wsel`=3.
- Forward priority:
  - Latched `e_rs`=5; `m_wen`=1, `m_wsel`=5, `m_wdat`=0xAAAA; `w_wsel`=5, `w_wdat`=0xBBBB → `safe_alu_in1`=0xAAAA.
  - Same with `m_wen`=0 → 0xBBBB.
  - With `e_rs`=0 → latched value.
- Load-use:
  - `e`=LW to $8, `d_rs`=8 → `hazard_stall`=1; next cycle `e_valid`=0 with `en`=1.
  - With `d_rt`=8 and `d_in2_is_reg`=0 and no store → `hazard_stall`=0.
- Hold refresh: latch `e_rt`=4 and set `en`=0; cycle 1 `w_wsel`=4, `w_wdat`=0x77; cycle 2 `w_wen`=0 → `safe_alu_in2` stays 0x77.
- Flush and halt:
  - flush=1 with `en`=0 → bubble next cycle.
  - Latch `d_halt`=1, then feed ADD with `en`=1 → `e_halt`=0 and `e_valid`=0 afterwards until RST.
- Reset mid-stall: `en`=0 with a valid entry, RST=1 for one edge → all outputs 0.
